// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, key-length encoding, Nk/Nr lookup and Rcon for the AES key schedule
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  localparam logic [1:0] KEY_LEN_128 = 2'd0;
  localparam logic [1:0] KEY_LEN_192 = 2'd1;
  localparam logic [1:0] KEY_LEN_256 = 2'd2;
  localparam logic [1:0] KEY_LEN_BAD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_DRAIN
  } state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KEY_LEN_192: return 4'd6;
      KEY_LEN_256: return 4'd8;
      default:     return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KEY_LEN_192: return 4'd12;
      KEY_LEN_256: return 4'd14;
      default:     return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// rtl/aes_key_schedule_seq_if.sv - start/round-key stream bundle for aes_key_schedule_seq
// The abort member exists only when AES_KEYSCHED_ABORT_EN is defined.
interface aes_key_schedule_seq_if;
  import aes_pkg::*;

  logic        start;
  logic        start_ready;
  logic [1:0]  key_len;
  logic [255:0] key;
  rkey_t       rk;
  logic [3:0]  rk_idx;
  logic        rk_valid;
  logic        rk_ready;
  logic        busy;
  logic        done;
  logic        err;
`ifdef AES_KEYSCHED_ABORT_EN
  logic        abort;

  modport master (
    output start, key_len, key, rk_ready, abort,
    input  start_ready, rk, rk_idx, rk_valid, busy, done, err
  );
  modport slave (
    input  start, key_len, key, rk_ready, abort,
    output start_ready, rk, rk_idx, rk_valid, busy, done, err
  );
`else
  modport master (
    output start, key_len, key, rk_ready,
    input  start_ready, rk, rk_idx, rk_valid, busy, done, err
  );
  modport slave (
    input  start, key_len, key, rk_ready,
    output start_ready, rk, rk_idx, rk_valid, busy, done, err
  );
`endif

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES byte S-box (GF(2^8) inverse followed by the affine map)
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;

  // inverse as a^254 = a^(2+4+...+128); zero maps to zero as required
  always_comb begin
    x2   = gmul(a, a);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// rtl/aes_key_schedule_seq.sv - sequential AES-128/192/256 key schedule streaming round keys via a FIFO
// Optional abort input is enabled by defining AES_KEYSCHED_ABORT_EN.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int SUPPORT_256 = 1
) (
  input  logic clk,
  input  logic rst,
  aes_key_schedule_seq_if.slave bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t        state_q, state_d;
  logic [255:0]  key_q;
  logic [3:0]    nk_q, nr_q;
  logic [5:0]    i_q;
  logic [2:0]    kmod_q;
  logic [3:0]    rcon_idx_q;
  word_t         win_q [8];

  rkey_t         fifo_rk  [FIFO_DEPTH];
  logic [3:0]    fifo_idx [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          done_q, err_q;

  logic  abort_w, len_ok, accept, fifo_full, fifo_empty, pop;
  logic  in_key, rot_step, mid_step, group_end, advance, push, last_word;
  word_t w_prev, w_back, sbox_in, sub_out, temp, w_new;

`ifdef AES_KEYSCHED_ABORT_EN
  assign abort_w = bus.abort && (state_q != ST_IDLE);
`else
  assign abort_w = 1'b0;
`endif

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign len_ok     = (bus.key_len != KEY_LEN_BAD) &&
                      ((SUPPORT_256 != 0) || (bus.key_len != KEY_LEN_256));
  assign accept     = (state_q == ST_IDLE) && bus.start && len_ok;
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && bus.rk_ready;

  // window slot k holds w[i-1-k], so w[i-Nk] sits at slot Nk-1
  assign w_prev = win_q[0];
  always_comb begin
    case (nk_q)
      4'd6:    w_back = win_q[5];
      4'd8:    w_back = win_q[7];
      default: w_back = win_q[3];
    endcase
  end

  assign in_key   = (i_q < {2'b00, nk_q});
  assign rot_step = (kmod_q == 3'd0);
  assign mid_step = (SUPPORT_256 != 0) && (nk_q == 4'd8) && (kmod_q == 3'd4);
  assign sbox_in  = rot_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sbox_in[8*b +: 8]), .s(sub_out[8*b +: 8]));
  end

  assign temp  = rot_step ? (sub_out ^ {rcon(rcon_idx_q), 24'h0}) :
                 mid_step ? sub_out : w_prev;
  assign w_new = in_key ? key_q[255:224] : (w_back ^ temp);

  // only the group-closing word needs FIFO space; a same-cycle pop frees it
  assign group_end = (i_q[1:0] == 2'd3);
  assign advance   = (state_q == ST_GEN) && !abort_w && (!group_end || !fifo_full || pop);
  assign push      = advance && group_end;
  assign last_word = (i_q == {nr_q, 2'b11});

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_GEN;
      ST_GEN: begin
        if (abort_w)                    state_d = ST_IDLE;
        else if (advance && last_word)  state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_w)                             state_d = ST_IDLE;
        else if (pop && (count_q == CW'(1)))     state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q      <= '0;
      nk_q       <= 4'd4;
      nr_q       <= 4'd10;
      i_q        <= '0;
      kmod_q     <= '0;
      rcon_idx_q <= 4'd1;
      for (int k = 0; k < 8; k++) win_q[k] <= '0;
    end else if (accept) begin
      key_q      <= bus.key;
      nk_q       <= nk_of(bus.key_len);
      nr_q       <= nr_of(bus.key_len);
      i_q        <= '0;
      kmod_q     <= '0;
      rcon_idx_q <= 4'd1;
    end else if (advance) begin
      i_q        <= i_q + 6'd1;
      kmod_q     <= ({1'b0, kmod_q} == nk_q - 4'd1) ? 3'd0 : kmod_q + 3'd1;
      if (rot_step && !in_key) rcon_idx_q <= rcon_idx_q + 4'd1;
      key_q      <= {key_q[223:0], 32'h0};
      win_q[0]   <= w_new;
      for (int k = 1; k < 8; k++) win_q[k] <= win_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rk[wptr_q]  <= {win_q[2], win_q[1], win_q[0], w_new};
      fifo_idx[wptr_q] <= i_q[5:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort_w) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (state_q == ST_DRAIN) && !abort_w && pop && (count_q == CW'(1));
      err_q  <= (state_q == ST_IDLE) && bus.start && !len_ok;
    end
  end

  assign bus.start_ready = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.rk_valid    = !fifo_empty;
  assign bus.rk          = fifo_empty ? '0 : fifo_rk[rptr_q];
  assign bus.rk_idx      = fifo_empty ? '0 : fifo_idx[rptr_q];
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb/tb_aes_key_schedule_seq.sv - self-checking bench: vector table, reference expansion model and scoreboard
module tb_aes_key_schedule_seq;

  logic clk;
  logic rst;

  aes_key_schedule_seq_if ifc ();

  aes_key_schedule_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   kl;
    logic [255:0] key;
    logic [3:0]   aidx;
    logic [127:0] ark;
  } vec_t;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
  } exp_t;

  vec_t   vt [4];
  exp_t   sb [$];
  logic [7:0] sbox_m [256];
  int     checks = 0;
  int     passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ ((p[7]) ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_m[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_m[0] = 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_m(input int j);
    logic [7:0] rc;
    rc = 8'h01;
    for (int n = 1; n < j; n++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    return rc;
  endfunction

  function automatic void expand(input logic [1:0] kl, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    int nk, nr;
    exp_t e;
    nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
    nr = nk + 6;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = k[255 - 32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0)                 t = subw({t[23:0], t[31:24]}) ^ {rcon_m(i / nk), 24'h0};
        else if (nk == 8 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) begin
      e.idx = 4'(r);
      e.rk  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      sb.push_back(e);
    end
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_rk"},          ifc.rk, 128'h0);
    chk({tag, "_rk_idx"},      128'(ifc.rk_idx), 128'h0);
    chk({tag, "_rk_valid"},    128'(ifc.rk_valid), 128'h0);
    chk({tag, "_busy"},        128'(ifc.busy), 128'h0);
    chk({tag, "_done"},        128'(ifc.done), 128'h0);
    chk({tag, "_err"},         128'(ifc.err), 128'h0);
    chk({tag, "_start_ready"}, 128'(ifc.start_ready), 128'h1);
  endtask

  task automatic run(input vec_t v, input int hold, input bit poke, input int rst_at);
    int nr, pops, t_first, t_last, held;
    int pop_cyc [16];
    bit finished, last_popped, stable, did_rst;
    logic [127:0] held_rk;
    exp_t e;
    nr = (v.kl == 2'd0) ? 10 : (v.kl == 2'd1) ? 12 : 14;
    sb.delete();
    expand(v.kl, v.key);
    ifc.start   = 1'b1;
    ifc.key_len = v.kl;
    ifc.key     = v.key;
    @(negedge clk);
    ifc.start   = 1'b0;
    ifc.key_len = 2'd3;
    ifc.key     = ~v.key;
    chk("busy_after_start", 128'(ifc.busy), 128'h1);
    chk("start_ready_busy", 128'(ifc.start_ready), 128'h0);
    pops = 0; t_first = -1; t_last = -1; held = 0; held_rk = '0;
    finished = 0; last_popped = 0; stable = 1; did_rst = 0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (last_popped) begin
        chk("done_pulse", 128'(ifc.done), 128'h1);
        chk("busy_clear", 128'(ifc.busy), 128'h0);
        finished = 1;
      end else begin
        if (rst_at >= 0 && ifc.rk_valid && ifc.rk_idx == 4'(rst_at)) begin
          rst = 1'b1;
          @(negedge clk);
          check_reset_values("mid_rst");
          rst = 1'b0;
          repeat (6) @(negedge clk);
          chk("post_rst_no_valid", 128'(ifc.rk_valid), 128'h0);
          did_rst = 1;
          break;
        end
        if (ifc.rk_valid && t_first < 0) begin
          t_first = cyc;
          if (hold > 0) begin
            ifc.rk_ready = 1'b0;
            held_rk = ifc.rk;
          end
        end
        if (ifc.rk_valid && ifc.rk_idx == 4'(nr) && t_last < 0) t_last = cyc;
        if (hold > 0 && !ifc.rk_ready) begin
          if (ifc.rk !== held_rk || ifc.rk_idx !== 4'd0 || ifc.rk_valid !== 1'b1) stable = 0;
          held++;
          if (held == hold) begin
            chk("bp_stable", 128'(stable), 128'h1);
            chk("bp_head_is_key", ifc.rk, v.key[255:128]);
            chk("bp_busy", 128'(ifc.busy), 128'h1);
            ifc.rk_ready = 1'b1;
          end
        end
        if (ifc.rk_valid && ifc.rk_ready) begin
          if (sb.size() == 0) chk("extra_pop", 128'h0, 128'h1);
          else begin
            e = sb.pop_front();
            chk("rk_idx", 128'(ifc.rk_idx), 128'(e.idx));
            chk("rk", ifc.rk, e.rk);
            if (ifc.rk_idx == v.aidx) chk("anchor_rk", ifc.rk, v.ark);
            if (e.idx == 4'(nr)) last_popped = 1;
          end
          if (pops < 16) pop_cyc[pops] = cyc;
          pops++;
        end
        ifc.start   = (poke && pops == 3);
        ifc.key_len = poke ? 2'd1 : 2'd3;
      end
      @(negedge clk);
    end
    ifc.start = 1'b0;
    if (did_rst) return;
    if (!finished) chk("timeout", 128'h0, 128'h1);
    else begin
      chk("pop_count", 128'(pops), 128'(nr + 1));
      chk("scoreboard_empty", 128'(sb.size()), 128'h0);
      if (hold == 0 && v.kl == 2'd0) begin
        chk("lat_first", 128'(t_first), 128'd4);
        chk("lat_last", 128'(t_last), 128'd44);
      end
      if (hold > 0) begin
        chk("bp_burst1", 128'(pop_cyc[1] - pop_cyc[0]), 128'd1);
        chk("bp_burst2", 128'(pop_cyc[2] - pop_cyc[1]), 128'd1);
        chk("bp_resume", 128'(pop_cyc[3] - pop_cyc[2]), 128'd3);
      end
      repeat (6) @(negedge clk);
      chk("idle_no_valid", 128'(ifc.rk_valid), 128'h0);
      chk("idle_start_ready", 128'(ifc.start_ready), 128'h1);
      chk("idle_done_low", 128'(ifc.done), 128'h0);
    end
  endtask

  initial begin
    vt[0] = '{2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_01234567_89abcdef},
              4'd1, 128'ha0fafe1788542cb123a339392a6c7605};
    vt[1] = '{2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
              4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[2] = '{2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffff_0000_ffff_0000},
              4'd12, 128'he98ba06f448c773c8ecc720401002202};
    vt[3] = '{2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
              4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
    build_sbox();

    rst          = 1'b1;
    ifc.start    = 1'b0;
    ifc.key_len  = 2'd0;
    ifc.key      = '0;
    ifc.rk_ready = 1'b1;
`ifdef AES_KEYSCHED_ABORT_EN
    ifc.abort    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 4; n++) run(vt[n], 0, (n == 0), -1);

    run(vt[1], 20, 0, -1);

    ifc.start   = 1'b1;
    ifc.key_len = 2'd3;
    @(negedge clk);
    ifc.start   = 1'b0;
    ifc.key_len = 2'd0;
    chk("err_pulse", 128'(ifc.err), 128'h1);
    chk("err_busy", 128'(ifc.busy), 128'h0);
    chk("err_no_valid", 128'(ifc.rk_valid), 128'h0);
    chk("err_start_ready", 128'(ifc.start_ready), 128'h1);
    @(negedge clk);
    chk("err_one_cycle", 128'(ifc.err), 128'h0);
    chk("err_still_idle", 128'(ifc.busy), 128'h0);

    run(vt[0], 0, 0, 5);
    run(vt[1], 0, 0, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
